// File: rtl/bpu_pkg.sv
// Shared types for the ID-side branch resolver: BTB update command and op codes.
package bpu_pkg;
  localparam int          BTB_IDX_W = 5;
  localparam logic [31:0] RESET_PC  = 32'h1c00_0000;

  typedef enum logic [2:0] {NONE, ADD, DEL, TGT_ERR, DIR_ERR, DIR_OK} upd_op_t;

  typedef struct packed {
    upd_op_t                op;
    logic [31:0]            pc;
    logic [BTB_IDX_W-1:0]   index;
    logic                   orien;
    logic [31:0]            target;
    logic                   push;
    logic                   pop;
  } upd_cmd_t;
endpackage

// File: rtl/bpu_upd_fifo.sv
// Synchronous FIFO of BTB update commands; almost_full leaves one slot of headroom.
module bpu_upd_fifo
  import bpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     resetn,
  input  logic     push,
  input  upd_cmd_t din,
  input  logic     pop,
  output upd_cmd_t head,
  output logic     empty,
  output logic     almost_full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] AF_LVL = (AW+1)'(DEPTH - 1);

  upd_cmd_t    mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, count;
  logic        full, do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when low bits match.
  assign count       = wr_ptr - rd_ptr;
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign almost_full = (count >= AF_LVL);
  assign do_push     = push && !full;
  assign do_pop      = pop && !empty;
  assign head        = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/bpu_resolve.sv
// ID-side branch resolver: classifies prediction outcome, issues redirects and
// queues BTB/RAS updates. Define BPU_PERF_CNT_EN to add CF/mispredict counters.
module bpu_resolve
  import bpu_pkg::*;
#(
  parameter int UPD_DEPTH = 4,
  parameter int IDX_W     = BTB_IDX_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic             br_epoch,
  input  logic [31:0]      br_pc,
  input  logic             br_is_cf,
  input  logic             br_is_call,
  input  logic             br_is_ret,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  input  logic             pred_en,
  input  logic             pred_taken,
  input  logic [31:0]      pred_target,
  input  logic [IDX_W-1:0] pred_index,
  output logic             flush_out,
  output logic [31:0]      redirect_pc,
  output logic             cur_epoch,
  input  logic             operate_ready,
  output logic             operate_en,
  output logic [31:0]      operate_pc,
  output logic [IDX_W-1:0] operate_index,
  output logic             add_entry,
  output logic             delete_entry,
  output logic             pre_error,
  output logic             pre_right,
  output logic             target_error,
  output logic             right_orien,
  output logic [31:0]      right_target,
  output logic             push_ras,
  output logic             pop_ras
`ifdef BPU_PERF_CNT_EN
  ,
  output logic [31:0]      perf_cf_cnt,
  output logic [31:0]      perf_miss_cnt
`endif
);
  logic        accept, live, mispred, enq, empty, almost_full;
  logic [31:0] seq_pc, fix_pc;
  upd_cmd_t    cmd, head, cur;

  assign accept = br_valid && br_ready;
  // Wrong-path instructions carry the pre-flush epoch and are ignored entirely.
  assign live   = accept && (br_epoch == cur_epoch);
  assign seq_pc = br_pc + 32'd4;

  always_comb begin
    cmd        = '0;
    cmd.op     = NONE;
    cmd.pc     = br_pc;
    cmd.index  = BTB_IDX_W'(pred_index);
    cmd.orien  = br_taken;
    cmd.target = br_target;
    cmd.push   = br_is_call;
    cmd.pop    = br_is_ret;
    mispred    = 1'b0;
    fix_pc     = br_target;
    if (!br_is_cf) begin
      if (pred_en) begin
        cmd.op  = DEL;
        mispred = pred_taken;
        fix_pc  = seq_pc;
      end
    end else if (!pred_en) begin
      if (br_taken) cmd.op = ADD;
      mispred = br_taken;
    end else if (br_taken && pred_taken && (pred_target != br_target) && !br_is_ret) begin
      // Return targets come from the RAS, so a stale BTB target is not an error.
      cmd.op  = TGT_ERR;
      mispred = 1'b1;
    end else if (pred_taken != br_taken) begin
      cmd.op  = DIR_ERR;
      mispred = 1'b1;
      fix_pc  = br_taken ? br_target : seq_pc;
    end else begin
      cmd.op = DIR_OK;
    end
  end

  assign enq = live && ((cmd.op != NONE) || cmd.push || cmd.pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      flush_out   <= 1'b0;
      redirect_pc <= RESET_PC;
      cur_epoch   <= 1'b0;
    end else begin
      flush_out <= live && mispred;
      if (live && mispred) begin
        redirect_pc <= fix_pc;
        cur_epoch   <= ~cur_epoch;
      end
    end
  end

  bpu_upd_fifo #(.DEPTH(UPD_DEPTH)) u_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .push        (enq),
    .din         (cmd),
    .pop         (operate_ready),
    .head        (head),
    .empty       (empty),
    .almost_full (almost_full)
  );

  assign br_ready      = !almost_full;
  assign operate_en    = !empty;
  assign cur           = empty ? '0 : head;
  assign operate_pc    = cur.pc;
  assign operate_index = IDX_W'(cur.index);
  assign add_entry     = (cur.op == ADD);
  assign delete_entry  = (cur.op == DEL);
  assign target_error  = (cur.op == TGT_ERR);
  assign pre_error     = (cur.op == DIR_ERR);
  assign pre_right     = (cur.op == DIR_OK);
  assign right_orien   = cur.orien;
  assign right_target  = cur.target;
  assign push_ras      = cur.push;
  assign pop_ras       = cur.pop;

`ifdef BPU_PERF_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_cf_cnt   <= '0;
      perf_miss_cnt <= '0;
    end else begin
      if (live && br_is_cf) perf_cf_cnt   <= perf_cf_cnt + 32'd1;
      if (live && mispred)  perf_miss_cnt <= perf_miss_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_bpu_resolve.sv
// Bench for bpu_resolve: vector table plus scoreboarded update/flush streams.
`timescale 1ns/1ps
module tb_bpu_resolve;
  import bpu_pkg::*;

  logic        clk = 1'b0, resetn = 1'b0;
  logic        br_valid, br_ready, br_epoch, br_is_cf, br_is_call, br_is_ret, br_taken;
  logic [31:0] br_pc, br_target, pred_target;
  logic        pred_en, pred_taken;
  logic [4:0]  pred_index, operate_index;
  logic        flush_out, cur_epoch, operate_ready, operate_en;
  logic [31:0] redirect_pc, operate_pc, right_target;
  logic        add_entry, delete_entry, pre_error, pre_right, target_error;
  logic        right_orien, push_ras, pop_ras;

  always #5 clk = ~clk;

  bpu_resolve #(.UPD_DEPTH(4), .IDX_W(5)) dut (
    .clk(clk), .resetn(resetn), .br_valid(br_valid), .br_ready(br_ready),
    .br_epoch(br_epoch), .br_pc(br_pc), .br_is_cf(br_is_cf), .br_is_call(br_is_call),
    .br_is_ret(br_is_ret), .br_taken(br_taken), .br_target(br_target),
    .pred_en(pred_en), .pred_taken(pred_taken), .pred_target(pred_target),
    .pred_index(pred_index), .flush_out(flush_out), .redirect_pc(redirect_pc),
    .cur_epoch(cur_epoch), .operate_ready(operate_ready), .operate_en(operate_en),
    .operate_pc(operate_pc), .operate_index(operate_index), .add_entry(add_entry),
    .delete_entry(delete_entry), .pre_error(pre_error), .pre_right(pre_right),
    .target_error(target_error), .right_orien(right_orien), .right_target(right_target),
    .push_ras(push_ras), .pop_ras(pop_ras)
  );

  typedef struct {
    logic        is_cf, is_call, is_ret, taken;
    logic [31:0] pc, target;
    logic        pen, ptaken;
    logic [31:0] ptarget;
    logic [4:0]  pidx;
    upd_op_t     op;
    logic        flush;
    logic [31:0] redir;
  } vec_t;

  int          n_cmp = 0, n_err = 0, n_flush = 0, n_cmd = 0;
  logic        tb_epoch = 1'b0;
  logic [76:0] exp_q [$];
  logic [31:0] flush_q [$];
  logic [76:0] dut_cmd;

  assign dut_cmd = {add_entry, delete_entry, target_error, pre_error, pre_right,
                    operate_pc, operate_index, right_orien, right_target, push_ras, pop_ras};

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic cf, call, ret, tk, input logic [31:0] pc, tgt,
                              input logic pe, pt, input logic [31:0] ptg, input logic [4:0] pi,
                              input upd_op_t op, input logic fl, input logic [31:0] rd);
    vec_t v;
    v.is_cf = cf; v.is_call = call; v.is_ret = ret; v.taken = tk; v.pc = pc; v.target = tgt;
    v.pen = pe; v.ptaken = pt; v.ptarget = ptg; v.pidx = pi; v.op = op; v.flush = fl; v.redir = rd;
    return v;
  endfunction

  function automatic vec_t mk_ok(input logic [31:0] pc, input logic [4:0] idx);
    return mk(1, 0, 0, 1, pc, pc + 32'h100, 1, 1, pc + 32'h100, idx, DIR_OK, 0, 0);
  endfunction

  function automatic logic [76:0] pack_exp(input vec_t v);
    return {v.op == ADD, v.op == DEL, v.op == TGT_ERR, v.op == DIR_ERR, v.op == DIR_OK,
            v.pc, v.pidx, v.taken, v.target, v.is_call, v.is_ret};
  endfunction

  // Scoreboard consumers: every presented command / flush must match the next expectation.
  always @(negedge clk) begin
    if (resetn) begin
      check("cur_epoch", 128'(cur_epoch), 128'(tb_epoch));
      if (operate_en && operate_ready) begin
        n_cmd++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_cmd: got pc %0h expected no command", operate_pc);
        end else check("update_cmd", 128'(dut_cmd), 128'(exp_q.pop_front()));
      end
      if (flush_out) begin
        n_flush++;
        if (flush_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_flush: got redirect %0h expected no flush", redirect_pc);
        end else check("redirect_pc", 128'(redirect_pc), 128'(flush_q.pop_front()));
      end
    end
  end

  task automatic send(input vec_t v, input logic stale);
    int w = 0;
    @(negedge clk);
    br_valid = 1; br_epoch = stale ? ~tb_epoch : tb_epoch;
    br_pc = v.pc; br_is_cf = v.is_cf; br_is_call = v.is_call; br_is_ret = v.is_ret;
    br_taken = v.taken; br_target = v.target; pred_en = v.pen; pred_taken = v.ptaken;
    pred_target = v.ptarget; pred_index = v.pidx;
    while (!br_ready && w < 50) begin @(negedge clk); w++; end
    if (!br_ready) begin
      n_cmp++; n_err++;
      $display("FAIL br_ready_timeout: got br_ready=0 for 50 cycles expected 1");
      br_valid = 0;
      return;
    end
    if (!stale) begin
      if (v.op != NONE || v.is_call || v.is_ret) exp_q.push_back(pack_exp(v));
      if (v.flush) flush_q.push_back(v.redir);
    end
    @(posedge clk);
    if (!stale && v.flush) tb_epoch = ~tb_epoch;
    #1 br_valid = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vt [12];
    int f0, c0;
    vt[0]  = mk(0,0,0,0, 32'h1c000010, 32'h0,        1,1, 32'h1c000080, 5'd3,  DEL,     1, 32'h1c000014);
    vt[1]  = mk(1,0,0,1, 32'h1c000020, 32'h1c000100, 0,0, 32'h0,        5'd0,  ADD,     1, 32'h1c000100);
    vt[2]  = mk(1,0,0,1, 32'h1c000030, 32'h1c000300, 1,1, 32'h1c000200, 5'd7,  TGT_ERR, 1, 32'h1c000300);
    vt[3]  = mk(1,0,1,1, 32'h1c000030, 32'h1c000300, 1,1, 32'h1c000200, 5'd7,  DIR_OK,  0, 32'h0);
    vt[4]  = mk(1,0,0,1, 32'h1c000040, 32'h1c000080, 1,0, 32'h0,        5'd2,  DIR_ERR, 1, 32'h1c000080);
    vt[5]  = mk(1,0,0,0, 32'h1c000050, 32'h1c000090, 1,1, 32'h1c000090, 5'd4,  DIR_ERR, 1, 32'h1c000054);
    vt[6]  = mk(0,0,0,0, 32'h1c000060, 32'h0,        1,0, 32'h0,        5'd9,  DEL,     0, 32'h0);
    vt[7]  = mk(1,0,0,0, 32'h1c000064, 32'h1c0000f0, 0,0, 32'h0,        5'd0,  NONE,    0, 32'h0);
    vt[8]  = mk(1,1,0,1, 32'h1c000070, 32'h1c000400, 0,0, 32'h0,        5'd0,  ADD,     1, 32'h1c000400);
    vt[9]  = mk(1,0,1,0, 32'h1c000074, 32'h1c000500, 0,0, 32'h0,        5'd0,  NONE,    0, 32'h0);
    vt[10] = mk(0,0,0,0, 32'h1c000078, 32'h0,        0,0, 32'h0,        5'd0,  NONE,    0, 32'h0);
    vt[11] = mk(1,1,0,1, 32'h1c0000a0, 32'h1c000500, 1,1, 32'h1c000500, 5'd12, DIR_OK,  0, 32'h0);

    br_valid = 0; br_epoch = 0; br_pc = 0; br_is_cf = 0; br_is_call = 0; br_is_ret = 0;
    br_taken = 0; br_target = 0; pred_en = 0; pred_taken = 0; pred_target = 0; pred_index = 0;
    operate_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_flush",    128'(flush_out),   128'(0));
    check("rst_redirect", 128'(redirect_pc), 128'(32'h1c000000));
    check("rst_epoch",    128'(cur_epoch),   128'(0));
    check("rst_cmd",      128'({operate_en, dut_cmd}), 128'(0));
    check("rst_ready",    128'(br_ready),    128'(1));
    resetn = 1;

    for (int i = 0; i < 12; i++) begin
      send(vt[i], 0);
      repeat (3) @(negedge clk);
    end

    // Mispredict followed by a wrong-path mispredict that still carries the old epoch.
    f0 = n_flush; c0 = n_cmd;
    send(mk(1,0,0,1, 32'h1c000600, 32'h1c000700, 0,0, 32'h0, 5'd0, ADD, 1, 32'h1c000700), 0);
    send(mk(0,0,0,0, 32'h1c000700, 32'h0, 1,1, 32'h1c000900, 5'd6, DEL, 1, 32'h1c000704), 1);
    repeat (4) @(negedge clk);
    check("b2b_flush_cnt", 128'(n_flush - f0), 128'(1));
    check("b2b_cmd_cnt",   128'(n_cmd - c0),   128'(1));

    // Update port stalled: queue fills, br_ready drops with one slot left.
    @(posedge clk); #1 operate_ready = 0;
    for (int k = 0; k < 3; k++) begin
      send(mk_ok(32'h1c000800 + 32'(k * 16), 5'(k + 1)), 0);
      if (k == 1) begin
        @(negedge clk);
        check("bp_ready_after2", 128'(br_ready), 128'(1));
      end
    end
    @(negedge clk);
    check("bp_ready_after3", 128'(br_ready), 128'(0));
    fork
      send(mk_ok(32'h1c000830, 5'd4), 0);
      begin repeat (3) @(posedge clk); #1 operate_ready = 1; end
    join
    repeat (8) @(negedge clk);
    check("bp_drained", 128'(exp_q.size()), 128'(0));

    // Reset with commands pending discards them.
    @(posedge clk); #1 operate_ready = 0;
    send(mk_ok(32'h1c000900, 5'd1), 0);
    send(mk_ok(32'h1c000910, 5'd2), 0);
    @(negedge clk);
    check("pre_rst_en", 128'(operate_en), 128'(1));
    #2 resetn = 0;
    #1;
    check("mid_rst_en",       128'(operate_en),  128'(0));
    check("mid_rst_redirect", 128'(redirect_pc), 128'(32'h1c000000));
    check("mid_rst_ready",    128'(br_ready),    128'(1));
    check("mid_rst_epoch",    128'(cur_epoch),   128'(0));
    exp_q.delete(); flush_q.delete(); tb_epoch = 0;
    #3 resetn = 1; operate_ready = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_idle", 128'(operate_en), 128'(0));
    end
    send(vt[0], 0);
    repeat (4) @(negedge clk);

    check("end_cmd_q",   128'(exp_q.size()),   128'(0));
    check("end_flush_q", 128'(flush_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
